// File: rtl/vehicle_sensor_conditioner.sv
// Loop-detector conditioning: per-channel 2-flop sync, debounce filter and
// stuck-high fault flagging, with S5 queue demand implying S1 demand.
module vehicle_sensor_conditioner #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned STUCK_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_S1_NS,
  input  logic       raw_S1_SN,
  input  logic       raw_S1_EW,
  input  logic       raw_S1_WE,
  input  logic       raw_S5_NS,
  input  logic       raw_S5_SN,
  input  logic       raw_S5_EW,
  input  logic       raw_S5_WE,
  input  logic       fault_clr,
  output logic       S1_NS,
  output logic       S1_SN,
  output logic       S1_EW,
  output logic       S1_WE,
  output logic       S5_NS,
  output logic       S5_SN,
  output logic       S5_EW,
  output logic       S5_WE,
  output logic [7:0] fault
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [15:0] STUCK_MAX = 16'(STUCK_CYCLES);

  logic [7:0]    raw;
  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    filt;
  logic [7:0]    fault_r;
  logic [7:0]    fault_set;
  logic [CW-1:0] cnt       [8];
  logic [15:0]   stuck     [8];
  logic [15:0]   stuck_nxt [8];

  assign raw = {raw_S5_WE, raw_S5_EW, raw_S5_SN, raw_S5_NS,
                raw_S1_WE, raw_S1_EW, raw_S1_SN, raw_S1_NS};

  // A saturated counter keeps the set condition asserted so it beats fault_clr.
  always_comb begin
    fault_set = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      stuck_nxt[i] = '0;
      if (filt[i]) begin
        stuck_nxt[i] = (stuck[i] == STUCK_MAX) ? STUCK_MAX : stuck[i] + 16'd1;
      end
      fault_set[i] = filt[i] && (stuck_nxt[i] == STUCK_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      filt    <= '0;
      fault_r <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        cnt[i]   <= '0;
        stuck[i] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      fault_r <= (fault_clr ? 8'h00 : fault_r) | fault_set;
      for (int unsigned i = 0; i < 8; i++) begin
        stuck[i] <= stuck_nxt[i];
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign S5_NS = filt[4];
  assign S5_SN = filt[5];
  assign S5_EW = filt[6];
  assign S5_WE = filt[7];
  assign S1_NS = filt[0] | filt[4];
  assign S1_SN = filt[1] | filt[5];
  assign S1_EW = filt[2] | filt[6];
  assign S1_WE = filt[3] | filt[7];
  assign fault = fault_r;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Scoreboard bench for vehicle_sensor_conditioner: a window-based reference
// model predicts demands and fault flags per clock edge; a monitor checks them.
module tb_vehicle_sensor_conditioner;

  localparam int unsigned DEB   = 4;
  localparam int unsigned STUCK = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] raw_v = 8'hFF;
  logic       fault_clr = 1'b0;
  logic       S1_NS, S1_SN, S1_EW, S1_WE, S5_NS, S5_SN, S5_EW, S5_WE;
  logic [7:0] fault;

  int unsigned tests = 0;
  int unsigned failed = 0;
  int unsigned pulse_req = 0;
  int unsigned pulse_ack = 0;
  int unsigned cyc = 0;

  logic [15:0] exp_q [$];

  // Reference state: raw samples seen at each edge (newest first), filter
  // outputs, consecutive edges spent high, and the sticky fault flags.
  bit          hist [8][$];
  int unsigned hi_run [8];
  logic [7:0]  m_filt;
  logic [7:0]  m_fault;

  vehicle_sensor_conditioner #(
    .DEB_CYCLES  (DEB),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raw_S1_NS(raw_v[0]),
    .raw_S1_SN(raw_v[1]),
    .raw_S1_EW(raw_v[2]),
    .raw_S1_WE(raw_v[3]),
    .raw_S5_NS(raw_v[4]),
    .raw_S5_SN(raw_v[5]),
    .raw_S5_EW(raw_v[6]),
    .raw_S5_WE(raw_v[7]),
    .fault_clr(fault_clr),
    .S1_NS    (S1_NS),
    .S1_SN    (S1_SN),
    .S1_EW    (S1_EW),
    .S1_WE    (S1_WE),
    .S5_NS    (S5_NS),
    .S5_SN    (S5_SN),
    .S5_EW    (S5_EW),
    .S5_WE    (S5_WE),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int c = 0; c < 8; c++) begin
      hist[c] = {};
      for (int k = 0; k < int'(DEB) + 2; k++) hist[c].push_back(1'b0);
      hi_run[c] = 0;
    end
    m_filt  = '0;
    m_fault = '0;
  endtask

  // A channel's filter flips once the DEB samples that have cleared the
  // two-stage synchronizer all disagree with the current filtered value.
  task automatic model_edge();
    logic [7:0] set_v;
    logic [7:0] nf;
    bit         all_diff;
    set_v = '0;
    nf    = m_filt;
    for (int c = 0; c < 8; c++) begin
      hist[c].push_front(raw_v[c]);
      void'(hist[c].pop_back());
      if (m_filt[c]) begin
        hi_run[c]++;
        if (hi_run[c] >= STUCK) set_v[c] = 1'b1;
      end else begin
        hi_run[c] = 0;
      end
      all_diff = 1'b1;
      for (int k = 2; k < int'(DEB) + 2; k++)
        if (hist[c][k] == m_filt[c]) all_diff = 1'b0;
      if (all_diff) nf[c] = ~m_filt[c];
    end
    m_fault = (fault_clr ? 8'h00 : m_fault) | set_v;
    m_filt  = nf;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (!rst || pulse_ack != pulse_req) begin
        model_clear();
        pulse_ack = pulse_req;
      end
      if (rst) model_edge();
      exp_q.push_back({m_fault, m_filt[7:4], m_filt[3:0] | m_filt[7:4]});
    end
  end

  initial begin : monitor
    logic [15:0] e;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {fault, S5_WE, S5_EW, S5_SN, S5_NS, S1_WE, S1_EW, S1_SN, S1_NS};
        tests++;
        if (a !== e) begin
          failed++;
          $display("FAIL demand/fault cycle %0d: got fault=%h S5/S1=%b required fault=%h S5/S1=%b",
                   cyc, a[15:8], a[7:0], e[15:8], e[7:0]);
        end
        cyc++;
      end
    end
  end

  task automatic drive(input logic [7:0] r, input logic clr);
    @(negedge clk);
    #1;
    raw_v     = r;
    fault_clr = clr;
  endtask

  task automatic hold(input logic [7:0] r, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(r, 1'b0);
  endtask

  initial begin : stimulus
    int unsigned hold_cnt [8];
    logic [7:0]  r;
    // Reset with every detector active, then release and keep them active.
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    hold(8'hFF, 25);
    drive(8'hFF, 1'b1);
    hold(8'h10, 10);
    drive(8'h10, 1'b1);
    hold(8'h00, 10);
    drive(8'h00, 1'b1);
    hold(8'h04, 3);
    hold(8'h00, 8);
    hold(8'h04, 8);
    hold(8'h00, 8);
    hold(8'h80, 8);
    hold(8'h00, 8);
    // Short reset glitch while a channel is mid-debounce.
    hold(8'h01, 3);
    @(negedge clk);
    #1 rst = 1'b0;
    pulse_req++;
    #1;
    tests++;
    if (fault !== 8'h00) begin
      failed++;
      $display("FAIL async reset: got fault=%h required 00", fault);
    end
    tests++;
    if ({S5_WE, S5_EW, S5_SN, S5_NS} !== 4'h0) begin
      failed++;
      $display("FAIL async reset: got S5=%b required 0000", {S5_WE, S5_EW, S5_SN, S5_NS});
    end
    tests++;
    if ({S1_WE, S1_EW, S1_SN, S1_NS} !== 4'h0) begin
      failed++;
      $display("FAIL async reset: got S1=%b required 0000", {S1_WE, S1_EW, S1_SN, S1_NS});
    end
    rst = 1'b1;
    hold(8'h01, 8);
    hold(8'h00, 8);

    r = '0;
    for (int c = 0; c < 8; c++) hold_cnt[c] = 0;
    for (int unsigned t = 0; t < 1500; t++) begin
      for (int c = 0; c < 8; c++) begin
        if (hold_cnt[c] == 0) begin
          r[c] = ~r[c];
          hold_cnt[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 30)
                                                    : $urandom_range(1, 7);
        end
        hold_cnt[c]--;
      end
      drive(r, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        pulse_req++;
        #1 rst = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end
    drive(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done, required completion", tests);
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "timeout");
  end

endmodule
